if_id_stage: RTL and testbench

//   Pipeline boundary between fetch and decode. Registers the fetched instruction and its sequential PC.

---
 rtl/if_id_stage_pkg.sv | 18 +
 rtl/if_id_field.sv | 20 ++
 rtl/if_id_stage.sv | 80 ++++++++
 tb/tb_if_id_stage.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/if_id_stage_pkg.sv
// rtl/if_id_stage_pkg.sv - shared constants, state encoding and field helpers for the IF/ID boundary
package if_id_stage_pkg;

  localparam int unsigned WIDTH     = 16;
  localparam logic [15:0] NOP_INSTR = 16'h0800;
  localparam logic [4:0]  HALT_OP   = 5'b00000;

  typedef enum logic [1:0] {
    ST_BUBBLE = 2'b00,
    ST_RUN    = 2'b01,
    ST_HALTED = 2'b10
  } state_t;

  function automatic logic [4:0] opcode(input logic [15:0] instr);
    return instr[15:11];
  endfunction

endpackage

// File: rtl/if_id_field.sv
// rtl/if_id_field.sv - enable/clear register with async reset to a parameterised value
module if_id_field #(
  parameter int unsigned   W       = 16,
  parameter logic [W-1:0]  RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      q <= RST_VAL;
    else if (clr) q <= RST_VAL;
    else if (en)  q <= d;
  end

endmodule

// File: rtl/if_id_stage.sv
// rtl/if_id_stage.sv - fetch/decode pipeline register with bubble insertion, stall hold and HALT freeze
module if_id_stage
  import if_id_stage_pkg::*;
#(
  parameter int unsigned        WIDTH     = if_id_stage_pkg::WIDTH,
  parameter logic [WIDTH-1:0]   NOP_INSTR = if_id_stage_pkg::NOP_INSTR,
  parameter logic [4:0]         HALT_OP   = if_id_stage_pkg::HALT_OP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] fe_instruc,
  input  logic [WIDTH-1:0] fe_seq_PC,
  input  logic             fe_ready,
  input  logic             stall,
  input  logic             flush,
  output logic             en_PC,
  output logic [WIDTH-1:0] id_instruc,
  output logic [WIDTH-1:0] id_seq_PC,
  output logic             id_valid,
  output logic             halted
);

  logic [1:0]       state_raw;
  state_t           state_q;
  state_t           state_d;
  logic             ld_en;
  logic             clr;
  logic [WIDTH-1:0] instr_d;
  logic [WIDTH-1:0] pc_d;

  assign state_q = state_t'(state_raw);
  assign halted  = (state_q == ST_HALTED);
  assign en_PC   = ~stall & ~halted & ~((state_q == ST_BUBBLE) & ~fe_ready);

  // Undefined memory output is never captured: without fe_ready the load is a bubble.
  assign instr_d = fe_ready ? fe_instruc : NOP_INSTR;
  assign pc_d    = fe_ready ? fe_seq_PC  : '0;

  always_comb begin
    ld_en   = 1'b0;
    clr     = 1'b0;
    state_d = state_q;
    if (flush) begin
      clr     = 1'b1;
      state_d = fe_ready ? ST_RUN : ST_BUBBLE;
    end else begin
      case (state_q)
        ST_BUBBLE, ST_RUN: begin
          if (!stall) begin
            ld_en = 1'b1;
            if (fe_ready)
              state_d = (opcode(fe_instruc) == HALT_OP) ? ST_HALTED : ST_RUN;
          end
        end
        ST_HALTED: state_d = ST_HALTED;
        default: begin
          clr     = 1'b1;
          state_d = ST_BUBBLE;
        end
      endcase
    end
  end

  if_id_field #(.W(2), .RST_VAL(ST_BUBBLE)) u_state (
    .clk(clk), .rst(rst), .en(1'b1), .clr(1'b0), .d(state_d), .q(state_raw)
  );

  if_id_field #(.W(WIDTH), .RST_VAL(NOP_INSTR)) u_instr (
    .clk(clk), .rst(rst), .en(ld_en), .clr(clr), .d(instr_d), .q(id_instruc)
  );

  if_id_field #(.W(WIDTH), .RST_VAL('0)) u_seq_pc (
    .clk(clk), .rst(rst), .en(ld_en), .clr(clr), .d(pc_d), .q(id_seq_PC)
  );

  if_id_field #(.W(1), .RST_VAL(1'b0)) u_valid (
    .clk(clk), .rst(rst), .en(ld_en), .clr(clr), .d(fe_ready), .q(id_valid)
  );

endmodule

// File: tb/tb_if_id_stage.sv
// tb/tb_if_id_stage.sv - directed vector table plus randomized model comparison for if_id_stage
module tb_if_id_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] fe_instruc;
  logic [15:0] fe_seq_PC;
  logic        fe_ready;
  logic        stall;
  logic        flush;
  logic        en_PC;
  logic [15:0] id_instruc;
  logic [15:0] id_seq_PC;
  logic        id_valid;
  logic        halted;

  int checks = 0;
  int errors = 0;

  if_id_stage dut (
    .clk(clk), .rst(rst), .fe_instruc(fe_instruc), .fe_seq_PC(fe_seq_PC),
    .fe_ready(fe_ready), .stall(stall), .flush(flush), .en_PC(en_PC),
    .id_instruc(id_instruc), .id_seq_PC(id_seq_PC), .id_valid(id_valid), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [15:0] instr;
    logic [15:0] pc;
    logic        rdy;
    logic        stl;
    logic        fl;
    logic        exp_en;
    logic [15:0] exp_instr;
    logic [15:0] exp_pc;
    logic        exp_valid;
    logic        exp_halted;
  } vec_t;

  vec_t vecs[$];

  // Reference model: what decode currently holds and whether the front end is frozen.
  logic [15:0] m_instr, m_pc;
  logic        m_valid, m_halted, m_waiting;

  task automatic model_reset();
    m_instr = 16'h0800; m_pc = 16'h0000; m_valid = 1'b0; m_halted = 1'b0; m_waiting = 1'b1;
  endtask

  function automatic logic model_en();
    return !stall && !m_halted && !(m_waiting && !fe_ready);
  endfunction

  task automatic model_edge();
    if (flush) begin
      m_instr = 16'h0800; m_pc = 16'h0000; m_valid = 1'b0; m_halted = 1'b0; m_waiting = !fe_ready;
    end else if (!stall && !m_halted) begin
      if (fe_ready) begin
        m_instr = fe_instruc; m_pc = fe_seq_PC; m_valid = 1'b1; m_waiting = 1'b0;
        m_halted = (fe_instruc[15:11] == 5'd0);
      end else begin
        m_instr = 16'h0800; m_pc = 16'h0000; m_valid = 1'b0;
      end
    end
  endtask

  task automatic drive(input logic [15:0] i, input logic [15:0] p, input logic r,
                       input logic s, input logic f);
    fe_instruc = i; fe_seq_PC = p; fe_ready = r; stall = s; flush = f;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_instr"},  {16'h0, id_instruc}, {16'h0, m_instr});
    chk({tag, "_pc"},     {16'h0, id_seq_PC},  {16'h0, m_pc});
    chk({tag, "_valid"},  {31'h0, id_valid},   {31'h0, m_valid});
    chk({tag, "_halted"}, {31'h0, halted},     {31'h0, m_halted});
  endtask

  initial begin
    rst = 1'b1;
    drive(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // inputs, en_PC during the cycle, then ID contents after the edge
    vecs.push_back('{16'h9999, 16'h0000, 0, 0, 0, 0, 16'h0800, 16'h0000, 0, 0});
    vecs.push_back('{16'hC123, 16'h0002, 1, 0, 0, 1, 16'hC123, 16'h0002, 1, 0});
    vecs.push_back('{16'hD0AC, 16'h0004, 1, 0, 0, 1, 16'hD0AC, 16'h0004, 1, 0});
    vecs.push_back('{16'hC123, 16'h0002, 1, 0, 0, 1, 16'hC123, 16'h0002, 1, 0});
    vecs.push_back('{16'h1111, 16'h0006, 1, 1, 0, 0, 16'hC123, 16'h0002, 1, 0});
    vecs.push_back('{16'h1111, 16'h0006, 1, 1, 0, 0, 16'hC123, 16'h0002, 1, 0});
    vecs.push_back('{16'h1111, 16'h0006, 1, 0, 0, 1, 16'h1111, 16'h0006, 1, 0});
    vecs.push_back('{16'h4A21, 16'h0008, 1, 0, 0, 1, 16'h4A21, 16'h0008, 1, 0});
    vecs.push_back('{16'h5555, 16'h000A, 1, 1, 1, 0, 16'h0800, 16'h0000, 0, 0});
    vecs.push_back('{16'h0800, 16'h000C, 1, 0, 0, 1, 16'h0800, 16'h000C, 1, 0});
    vecs.push_back('{16'h0000, 16'h000E, 1, 0, 0, 1, 16'h0000, 16'h000E, 1, 1});
    vecs.push_back('{16'h1234, 16'h0010, 1, 0, 0, 0, 16'h0000, 16'h000E, 1, 1});
    vecs.push_back('{16'h2222, 16'h0012, 1, 1, 0, 0, 16'h0000, 16'h000E, 1, 1});
    vecs.push_back('{16'h3333, 16'h0014, 0, 0, 0, 0, 16'h0000, 16'h000E, 1, 1});
    vecs.push_back('{16'h7777, 16'h0016, 1, 0, 1, 0, 16'h0800, 16'h0000, 0, 0});
    vecs.push_back('{16'h2005, 16'h0020, 1, 0, 0, 1, 16'h2005, 16'h0020, 1, 0});
    vecs.push_back('{16'hABCD, 16'h0022, 0, 0, 0, 1, 16'h0800, 16'h0000, 0, 0});

    foreach (vecs[k]) begin
      drive(vecs[k].instr, vecs[k].pc, vecs[k].rdy, vecs[k].stl, vecs[k].fl);
      #1;
      chk($sformatf("vec%0d_en_PC", k), {31'h0, en_PC}, {31'h0, vecs[k].exp_en});
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_instr", k),  {16'h0, id_instruc}, {16'h0, vecs[k].exp_instr});
      chk($sformatf("vec%0d_pc", k),     {16'h0, id_seq_PC},  {16'h0, vecs[k].exp_pc});
      chk($sformatf("vec%0d_valid", k),  {31'h0, id_valid},   {31'h0, vecs[k].exp_valid});
      chk($sformatf("vec%0d_halted", k), {31'h0, halted},     {31'h0, vecs[k].exp_halted});
      @(negedge clk);
    end

    // HALT held for 10 cycles against changing fetch data and toggling stall
    drive(16'h0000, 16'h0040, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    for (int c = 0; c < 10; c++) begin
      drive(16'(($urandom & 16'hF7FF) | 16'h0800), 16'(c * 2), 1'b1, 1'(c % 2), 1'b0);
      #1;
      chk("halt_hold_en_PC", {31'h0, en_PC}, 32'h0);
      @(posedge clk);
      #1;
      chk("halt_hold_instr",  {16'h0, id_instruc}, 32'h0000);
      chk("halt_hold_halted", {31'h0, halted}, 32'h1);
      @(negedge clk);
    end

    // asynchronous reset while halted takes effect without a clock edge
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs("async_rst");
    @(negedge clk);
    rst = 1'b0;

    // randomized traffic against the reference model
    for (int n = 0; n < 3000; n++) begin
      logic [15:0] ins;
      ins = 16'($urandom);
      if ($urandom_range(0, 15) == 0) ins[15:11] = 5'd0;
      drive(ins, 16'($urandom), ($urandom_range(0, 4) != 0),
            ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0));
      if ($urandom_range(0, 199) == 0) begin
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs("rand_rst");
        @(negedge clk);
        rst = 1'b0;
      end else begin
        #1;
        chk("rand_en_PC", {31'h0, en_PC}, {31'h0, model_en()});
        @(posedge clk);
        model_edge();
        #1;
        check_outputs("rand");
        @(negedge clk);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
